add_round_key: RTL and testbench

Registered AddRoundKey stage of the AES datapath. It XORs a 128-bit state word with the current round key and presents the result one clock later with a valid flag. It sits between the key-expansion output and the SubBytes/ShiftRows/MixColumns pipeline, and is used for the initial, middle and final rounds.

---
 rtl/aes_pkg.sv | 13 +
 rtl/ark_column.sv | 10 +
 rtl/add_round_key.sv | 46 ++++
 tb/tb_add_round_key.sv | 119 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths and column/state types
package aes_pkg;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_NCOL    = AES_BLOCK_W / AES_WORD_W;

    typedef logic [AES_WORD_W-1:0] aes_word_t;
    typedef aes_word_t [AES_NCOL-1:0] aes_state_t;

    function automatic aes_word_t xor_word(input aes_word_t a, input aes_word_t b);
        return a ^ b;
    endfunction
endpackage

// File: rtl/ark_column.sv
// ark_column: combinational XOR of one 32-bit state column with its key column
module ark_column
    import aes_pkg::*;
(
    input  aes_word_t state_col,
    input  aes_word_t key_col,
    output aes_word_t result_col
);
    assign result_col = xor_word(state_col, key_col);
endmodule

// File: rtl/add_round_key.sv
// add_round_key: registered AES AddRoundKey stage, 1-cycle latency, 1 word/cycle.
// ADD_ROUND_KEY_OUT_MASK_EN: when defined, data_out reads 0 whenever valid_out is 0.
module add_round_key
    import aes_pkg::*;
#(
    parameter int DATA_W = AES_BLOCK_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_valid_in,
    input  logic              key_valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] round_key,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out
);
    localparam int NCOL = DATA_W / AES_WORD_W;

    logic              accept;
    logic [DATA_W-1:0] xor_out;

    assign accept = data_valid_in & key_valid_in;

    for (genvar c = 0; c < NCOL; c++) begin : g_col
        ark_column u_col (
            .state_col (data_in[c*AES_WORD_W +: AES_WORD_W]),
            .key_col   (round_key[c*AES_WORD_W +: AES_WORD_W]),
            .result_col(xor_out[c*AES_WORD_W +: AES_WORD_W])
        );
    end

    // register the result on accept; a lone valid on either side is dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= accept;
`ifdef ADD_ROUND_KEY_OUT_MASK_EN
            data_out  <= accept ? xor_out : '0;
`else
            if (accept) data_out <= xor_out;
`endif
        end
    end
endmodule

// File: tb/tb_add_round_key.sv
// tb_add_round_key: randomized self-checking bench against a behavioural XOR model
module tb_add_round_key;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         data_valid_in = 1'b0;
    logic         key_valid_in = 1'b0;
    logic [127:0] data_in = '0;
    logic [127:0] round_key = '0;
    logic         valid_out;
    logic [127:0] data_out;

    int errors = 0;
    int checks = 0;

    logic         mdl_valid = 1'b0;
    logic [127:0] mdl_data = '0;

    add_round_key dut (
        .clk          (clk),
        .reset        (reset),
        .data_valid_in(data_valid_in),
        .key_valid_in (key_valid_in),
        .data_in      (data_in),
        .round_key    (round_key),
        .valid_out    (valid_out),
        .data_out     (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %032h expected %032h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // drive one cycle, advance the reference model at the edge, then compare
    task automatic cycle(input string tag, input logic dv, input logic kv,
                         input logic [127:0] d, input logic [127:0] k);
        data_valid_in = dv;
        key_valid_in  = kv;
        data_in       = d;
        round_key     = k;
        @(posedge clk);
        if (!reset) begin
            mdl_valid = 1'b0;
            mdl_data  = '0;
        end else if (dv && kv) begin
            mdl_valid = 1'b1;
            mdl_data  = d ^ k;
        end else begin
            mdl_valid = 1'b0;
`ifdef ADD_ROUND_KEY_OUT_MASK_EN
            mdl_data  = '0;
`endif
        end
        #1;
        check({tag, ".valid"}, {127'd0, valid_out}, {127'd0, mdl_valid});
        check({tag, ".data"}, data_out, mdl_data);
    endtask

    logic [127:0] r;
    logic [127:0] held;

    initial begin
        // held in reset with both valids high: outputs must stay cleared
        for (int i = 0; i < 4; i++) cycle("reset", 1'b1, 1'b1, rnd128(), rnd128());
        reset = 1'b1;

        // first edge after release accepts the known vector
        cycle("single", 1'b1, 1'b1, 128'h0123456789ABCDEFFEDCBA9876543210,
              128'h00112233445566778899AABBCCDDEEFF);
        check("single.const", data_out, 128'h01326754CDFEAB9876451023BA89DCEF);
        cycle("b2b", 1'b1, 1'b1, {128{1'b1}}, '0);
        check("b2b.const", data_out, {128{1'b1}});

        // one-sided valids are dropped
        held = data_out;
        cycle("part_d", 1'b1, 1'b0, rnd128(), rnd128());
        cycle("part_k", 1'b0, 1'b1, rnd128(), rnd128());
`ifdef ADD_ROUND_KEY_OUT_MASK_EN
        check("part.hold", data_out, '0);
`else
        check("part.hold", data_out, held);
`endif

        // asynchronous reset between edges while a result is showing
        cycle("pre_rst", 1'b1, 1'b1, rnd128(), rnd128());
        #2 reset = 1'b0;
        #1;
        check("async.valid", {127'd0, valid_out}, '0);
        check("async.data", data_out, '0);
        cycle("in_rst", 1'b1, 1'b1, rnd128(), rnd128());
        reset = 1'b1;
        cycle("post_rst", 1'b0, 1'b0, rnd128(), rnd128());
        check("post_rst.data", data_out, '0);

        // identity and self-inverse
        r = rnd128();
        cycle("ident", 1'b1, 1'b1, r, '0);
        check("ident.const", data_out, r);
        r = rnd128();
        cycle("inverse", 1'b1, 1'b1, r, r);
        check("inverse.const", data_out, '0);

        // random traffic with mixed valids
        for (int i = 0; i < 1000; i++)
            cycle("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rnd128(), rnd128());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
